// File: rtl/mult_gen.sv
// mult_gen: fully pipelined 32x32 -> 64 multiplier, signed or unsigned, LATENCY register stages.
module mult_gen #(
    parameter bit SIGNED  = 1'b1,
    parameter int LATENCY = 3
) (
    input  logic        CLK,
    input  logic        SCLR,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] P
);
    // High halves carry the operand sign in signed mode; low halves are always unsigned.
    logic signed [16:0] ah, al, bh, bl;
    logic signed [33:0] hh_c, hl_c, lh_c, ll_c;

    assign ah = {SIGNED ? A[31] : 1'b0, A[31:16]};
    assign al = {1'b0, A[15:0]};
    assign bh = {SIGNED ? B[31] : 1'b0, B[31:16]};
    assign bl = {1'b0, B[15:0]};

    assign hh_c = ah * bh;
    assign hl_c = ah * bl;
    assign lh_c = al * bh;
    assign ll_c = al * bl;

    function automatic logic [63:0] ext(input logic [33:0] x);
        return {{30{x[33]}}, x};
    endfunction

    // The true product always fits in 64 bits, so modulo-2^64 summation is exact.
    function automatic logic [63:0] psum(input logic [33:0] hh, hl, lh, ll);
        return (ext(hh) << 32) + ((ext(hl) + ext(lh)) << 16) + ext(ll);
    endfunction

    generate
        if (LATENCY == 1) begin : g_l1
            always_ff @(posedge CLK)
                P <= SCLR ? 64'd0 : psum(hh_c, hl_c, lh_c, ll_c);
        end else begin : g_ln
            logic [33:0] hh_q, hl_q, lh_q, ll_q;
            logic [63:0] sum_q [LATENCY-1];
            always_ff @(posedge CLK) begin
                if (SCLR) begin
                    hh_q <= '0;
                    hl_q <= '0;
                    lh_q <= '0;
                    ll_q <= '0;
                    for (int i = 0; i < LATENCY - 1; i++) sum_q[i] <= '0;
                end else begin
                    hh_q <= hh_c;
                    hl_q <= hl_c;
                    lh_q <= lh_c;
                    ll_q <= ll_c;
                    sum_q[0] <= psum(hh_q, hl_q, lh_q, ll_q);
                    for (int i = 1; i < LATENCY - 1; i++) sum_q[i] <= sum_q[i-1];
                end
            end
            assign P = sum_q[LATENCY-2];
        end
    endgenerate
endmodule

// File: tb/tb_mult_gen.sv
// tb_mult_gen: directed vectors, multi-cycle corner sequences and a cycle-accurate scoreboard
// over four configurations (signed/unsigned, latency 1/3/6).
module tb_mult_gen;
    logic clk = 1'b0;
    logic sclr = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic [63:0] p0, p1, p2, p3;

    always #5 clk = ~clk;

    mult_gen #(.SIGNED(1'b1), .LATENCY(3)) d0 (.CLK(clk), .SCLR(sclr), .A(a), .B(b), .P(p0));
    mult_gen #(.SIGNED(1'b0), .LATENCY(3)) d1 (.CLK(clk), .SCLR(sclr), .A(a), .B(b), .P(p1));
    mult_gen #(.SIGNED(1'b1), .LATENCY(1)) d2 (.CLK(clk), .SCLR(sclr), .A(a), .B(b), .P(p2));
    mult_gen #(.SIGNED(1'b0), .LATENCY(6)) d3 (.CLK(clk), .SCLR(sclr), .A(a), .B(b), .P(p3));

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input bit s);
        logic signed [63:0] sx, sy;
        sx = s ? {{32{x[31]}}, x} : {32'd0, x};
        sy = s ? {{32{y[31]}}, y} : {32'd0, y};
        return sx * sy;
    endfunction

    localparam int DEPTH = 12000;
    logic [31:0] cap_a [DEPTH];
    logic [31:0] cap_b [DEPTH];
    int e = 0, last_rst = -1;

    always @(posedge clk) begin
        if (e < DEPTH) begin
            cap_a[e] = a;
            cap_b[e] = b;
            if (sclr) last_rst = e;
            e++;
        end
    end

    function automatic logic [63:0] expect_p(input int lat, input bit s);
        int idx;
        idx = e - lat;
        if (idx > last_rst) return model(cap_a[idx], cap_b[idx], s);
        return 64'd0;
    endfunction

    always @(negedge clk) begin
        if (last_rst >= 0 && e < DEPTH) begin
            check("sb_s_l3", p0, expect_p(3, 1'b1));
            check("sb_u_l3", p1, expect_p(3, 1'b0));
            check("sb_s_l1", p2, expect_p(1, 1'b1));
            check("sb_u_l6", p3, expect_p(6, 1'b0));
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_s;
        logic [63:0] exp_u;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{32'd3, 32'd3, 64'h0000000000000009, 64'h0000000000000009};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 64'hFFFFFFFE00000001};
        vecs[2] = '{32'h80000000, 32'h80000000, 64'h4000000000000000, 64'h4000000000000000};
        vecs[3] = '{32'h80000000, 32'd1, 64'hFFFFFFFF80000000, 64'h0000000080000000};
        vecs[4] = '{32'h80000000, 32'd2, 64'hFFFFFFFF00000000, 64'h0000000100000000};
        vecs[5] = '{32'd7, 32'd6, 64'h000000000000002A, 64'h000000000000002A};
        vecs[6] = '{32'd0, 32'hDEADBEEF, 64'h0, 64'h0};
        vecs[7] = '{32'hFFFFFFFF, 32'd1, 64'hFFFFFFFFFFFFFFFF, 64'h00000000FFFFFFFF};
        vecs[8] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, 64'h3FFFFFFF00000001};
        vecs[9] = '{32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000, 64'h3FFFFFFF80000000};

        repeat (2) @(negedge clk);
        check("reset_s_l3", p0, 64'd0);
        check("reset_u_l3", p1, 64'd0);
        check("reset_s_l1", p2, 64'd0);
        check("reset_u_l6", p3, 64'd0);

        a = 32'd3; b = 32'd3;
        @(negedge clk);
        sclr = 1'b0;
        @(negedge clk);
        check("lat_edge1", p0, 64'd0);
        @(negedge clk);
        check("lat_edge2", p0, 64'd0);
        @(negedge clk);
        check("lat_edge3", p0, 64'd9);

        for (int i = 0; i < 10; i++) begin
            a = vecs[i].a; b = vecs[i].b;
            repeat (6) @(negedge clk);
            check("vec_s_l3", p0, vecs[i].exp_s);
            check("vec_u_l3", p1, vecs[i].exp_u);
            check("vec_s_l1", p2, vecs[i].exp_s);
            check("vec_u_l6", p3, vecs[i].exp_u);
        end

        for (int k = 1; k <= 100; k++) begin
            a = k; b = k;
            @(negedge clk);
            if (k >= 3) check("b2b_square", p0, 64'((k - 2) * (k - 2)));
        end

        a = 32'd7; b = 32'd6;
        @(negedge clk);
        a = 32'd5; b = 32'd5;
        @(negedge clk);
        sclr = 1'b1; a = 32'd0; b = 32'd0;
        @(negedge clk);
        sclr = 1'b0;
        check("flush_s_l3", p0, 64'd0);
        check("flush_u_l3", p1, 64'd0);
        check("flush_s_l1", p2, 64'd0);
        check("flush_u_l6", p3, 64'd0);
        repeat (8) begin
            @(negedge clk);
            check("flush_hold_s_l3", p0, 64'd0);
            check("flush_hold_u_l6", p3, 64'd0);
        end

        for (int i = 0; i < 10000; i++) begin
            a = ($urandom_range(0, 15) == 0) ? 32'h80000000 : $urandom;
            b = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFF : $urandom;
            sclr = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        sclr = 1'b0;
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
